// File: rtl/pipe_pc_pkg.sv
// rtl/pipe_pc_pkg.sv - FSM states and redirect source codes for the fetch PC generator
package pipe_pc_pkg;

  typedef enum logic {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } pc_state_e;

  typedef enum logic [2:0] {
    SRC_SEQ  = 3'd0,
    SRC_JMP  = 3'd1,
    SRC_BR   = 3'd2,
    SRC_EXC  = 3'd3,
    SRC_PEND = 3'd4
  } pc_src_e;

  // True only for redirects arriving this cycle, not for a replayed pending target.
  function automatic logic is_incoming(input pc_src_e s);
    return (s == SRC_EXC) || (s == SRC_BR) || (s == SRC_JMP);
  endfunction

endpackage

// File: rtl/pipe_pc_redirect_sel.sv
// rtl/pipe_pc_redirect_sel.sv - priority mux: exc > br > jmp > pending > sequential
module pipe_pc_redirect_sel
  import pipe_pc_pkg::*;
#(
  parameter int               WIDTH   = 32,
  parameter logic [WIDTH-1:0] EXC_VEC = WIDTH'(32'h0000_0008),
  parameter int               INC     = 4
) (
  input  logic             run,
  input  logic             exc,
  input  logic             br_taken,
  input  logic [WIDTH-1:0] br_target,
  input  logic             jmp,
  input  logic [WIDTH-1:0] jmp_target,
  input  logic             pend_valid,
  input  logic [WIDTH-1:0] pend_target,
  input  logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_next,
  output pc_src_e          src
);

  always_comb begin
    src     = SRC_SEQ;
    pc_next = pc + WIDTH'(INC);
    // During boot the PC is pinned, so every request is masked here.
    if (!run) begin
      pc_next = pc;
    end else if (exc) begin
      src     = SRC_EXC;
      pc_next = EXC_VEC;
    end else if (br_taken) begin
      src     = SRC_BR;
      pc_next = br_target;
    end else if (jmp) begin
      src     = SRC_JMP;
      pc_next = jmp_target;
    end else if (pend_valid) begin
      src     = SRC_PEND;
      pc_next = pend_target;
    end
  end

endmodule

// File: rtl/pipe_pc_gen.sv
// rtl/pipe_pc_gen.sv - fetch-stage PC register with boot window and stalled-redirect buffer
module pipe_pc_gen
  import pipe_pc_pkg::*;
#(
  parameter int               WIDTH      = 32,
  parameter logic [WIDTH-1:0] RESET_VEC  = WIDTH'(32'h0000_0000),
  parameter logic [WIDTH-1:0] EXC_VEC    = WIDTH'(32'h0000_0008),
  parameter int               INC        = 4,
  parameter int               ALIGN_BITS = 2
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             wpc,
  input  logic             exc,
  input  logic             br_taken,
  input  logic [WIDTH-1:0] br_target,
  input  logic             jmp,
  input  logic [WIDTH-1:0] jmp_target,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_next,
  output logic             pc_valid,
  output logic             redir_pend,
  output logic             misalign
);

  pc_state_e        state;
  pc_src_e          src;
  logic [WIDTH-1:0] pend_target;
  logic             pend_exc;
  logic             run;
  logic             incoming;

  assign run      = (state == ST_RUN);
  assign incoming = is_incoming(src);

  pipe_pc_redirect_sel #(
    .WIDTH   (WIDTH),
    .EXC_VEC (EXC_VEC),
    .INC     (INC)
  ) u_sel (
    .run         (run),
    .exc         (exc),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .jmp         (jmp),
    .jmp_target  (jmp_target),
    .pend_valid  (redir_pend),
    .pend_target (pend_target),
    .pc          (pc),
    .pc_next     (pc_next),
    .src         (src)
  );

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state       <= ST_BOOT;
      pc          <= RESET_VEC;
      pc_valid    <= 1'b0;
      redir_pend  <= 1'b0;
      pend_target <= '0;
      pend_exc    <= 1'b0;
    end else if (state == ST_BOOT) begin
      state    <= ST_RUN;
      pc_valid <= 1'b1;
    end else if (wpc) begin
      pc         <= pc_next;
      redir_pend <= 1'b0;
      pend_exc   <= 1'b0;
    end else if (incoming && !(redir_pend && pend_exc && (src != SRC_EXC))) begin
      // A held exception outranks any later non-exception redirect.
      pend_target <= pc_next;
      pend_exc    <= (src == SRC_EXC);
      redir_pend  <= 1'b1;
    end
  end

  if (ALIGN_BITS > 0) begin : g_align
    assign misalign = |pc[ALIGN_BITS-1:0];
  end else begin : g_noalign
    assign misalign = 1'b0;
  end

endmodule

// File: tb/tb_pipe_pc_gen.sv
// tb/tb_pipe_pc_gen.sv - vector table plus scoreboard bench for pipe_pc_gen
module tb_pipe_pc_gen;

  typedef struct {
    logic        rst;
    logic        wpc;
    logic        exc;
    logic        br;
    logic [31:0] bt;
    logic        jmp;
    logic [31:0] jt;
    logic [31:0] e_pc;
    logic        e_pend;
    logic        e_mis;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic        valid;
    logic        pend;
    logic        mis;
  } exp_t;

  logic        clk = 1'b0;
  logic        clrn = 1'b0;
  logic        wpc = 1'b0, exc = 1'b0, br_taken = 1'b0, jmp = 1'b0;
  logic [31:0] br_target = '0, jmp_target = '0;
  logic [31:0] pc, pc_next;
  logic        pc_valid, redir_pend, misalign;

  logic        wpc8 = 1'b0, exc8 = 1'b0, br8 = 1'b0, jmp8 = 1'b0;
  logic [7:0]  bt8 = '0, jt8 = '0;
  logic [7:0]  pc8, pc_next8;
  logic        valid8, pend8, mis8;

  int n_cmp = 0;
  int n_bad = 0;
  vec_t vecs[$];
  exp_t sb[$];

  always #5 clk = ~clk;

  pipe_pc_gen dut (
    .clk(clk), .clrn(clrn), .wpc(wpc), .exc(exc),
    .br_taken(br_taken), .br_target(br_target), .jmp(jmp), .jmp_target(jmp_target),
    .pc(pc), .pc_next(pc_next), .pc_valid(pc_valid), .redir_pend(redir_pend),
    .misalign(misalign)
  );

  pipe_pc_gen #(.WIDTH(8), .RESET_VEC(8'hFC), .EXC_VEC(8'h08), .INC(4), .ALIGN_BITS(2)) dut8 (
    .clk(clk), .clrn(clrn), .wpc(wpc8), .exc(exc8),
    .br_taken(br8), .br_target(bt8), .jmp(jmp8), .jmp_target(jt8),
    .pc(pc8), .pc_next(pc_next8), .pc_valid(valid8), .redir_pend(pend8),
    .misalign(mis8)
  );

  function automatic vec_t mk(input logic rst, input logic w, input logic e, input logic b,
                              input logic [31:0] bt, input logic j, input logic [31:0] jt,
                              input logic [31:0] p, input logic pd, input logic m);
    vec_t v;
    v.rst = rst; v.wpc = w; v.exc = e; v.br = b; v.bt = bt; v.jmp = j; v.jt = jt;
    v.e_pc = p; v.e_pend = pd; v.e_mis = m;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic pop_cmp(input string tag, input logic [31:0] a_pc, input logic a_valid,
                         input logic a_pend, input logic a_mis);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_pc"}, a_pc, e.pc);
      chk({tag, "_valid"}, 32'(a_valid), 32'(e.valid));
      chk({tag, "_pend"}, 32'(a_pend), 32'(e.pend));
      chk({tag, "_mis"}, 32'(a_mis), 32'(e.mis));
    end
  endtask

  initial begin
    vec_t v;
    // Boot and sequential stepping, then dual redirect (branch beats jump).
    vecs.push_back(mk(1, 1, 0, 0, 0,       0, 0,       32'h000, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0,       0, 0,       32'h004, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0,       0, 0,       32'h008, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0,       0, 0,       32'h00C, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0,       0, 0,       32'h010, 0, 0));
    vecs.push_back(mk(0, 1, 0, 1, 32'h40,  1, 32'h80,  32'h040, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0,       1, 32'h1C,  32'h01C, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0,       0, 0,       32'h020, 0, 0));
    // Stalled jump is pended and replayed on release.
    vecs.push_back(mk(0, 0, 0, 0, 0,       1, 32'h100, 32'h020, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,       0, 0,       32'h020, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0,       0, 0,       32'h100, 0, 0));
    // Held exception survives a later branch.
    vecs.push_back(mk(0, 0, 1, 0, 0,       0, 0,       32'h100, 1, 0));
    vecs.push_back(mk(0, 0, 0, 1, 32'h200, 0, 0,       32'h100, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0,       0, 0,       32'h008, 0, 0));
    // Newest non-exception redirect overwrites; exception replaces non-exception.
    vecs.push_back(mk(0, 0, 0, 1, 32'h300, 0, 0,       32'h008, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,       1, 32'h400, 32'h008, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0,       0, 0,       32'h400, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,       1, 32'h500, 32'h400, 1, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0,       0, 0,       32'h400, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0,       0, 0,       32'h008, 0, 0));
    // Incoming redirect wins over a pending one on release; misaligned targets.
    vecs.push_back(mk(0, 0, 0, 1, 32'h600, 0, 0,       32'h008, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0,       1, 32'h700, 32'h700, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0,       1, 32'h702, 32'h702, 0, 1));
    vecs.push_back(mk(0, 1, 0, 0, 0,       0, 0,       32'h706, 0, 1));
    // Pend then reset mid-cycle; redirects in BOOT are ignored.
    vecs.push_back(mk(0, 0, 0, 1, 32'h900, 0, 0,       32'h706, 1, 1));
    vecs.push_back(mk(1, 1, 0, 1, 32'h40,  0, 0,       32'h000, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0,       0, 0,       32'h004, 0, 0));
    vecs.push_back(mk(1, 0, 1, 0, 0,       0, 0,       32'h000, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0,       0, 0,       32'h004, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      if (v.rst) begin
        #1 clrn = 1'b0;
        #1;
        chk("rst_pc", pc, 32'h0);
        chk("rst_valid", 32'(pc_valid), 32'h0);
        chk("rst_pend", 32'(redir_pend), 32'h0);
        chk("rst_mis", 32'(misalign), 32'h0);
        @(negedge clk);
        clrn = 1'b1;
      end else begin
        @(negedge clk);
      end
      wpc = v.wpc; exc = v.exc; br_taken = v.br; br_target = v.bt;
      jmp = v.jmp; jmp_target = v.jt;
      sb.push_back('{pc: v.e_pc, valid: 1'b1, pend: v.e_pend, mis: v.e_mis});
      @(posedge clk);
      #1;
      pop_cmp($sformatf("v%0d", i), pc, pc_valid, redir_pend, misalign);
    end

    // 8-bit instance has been stalled at its reset vector since the last reset.
    @(negedge clk);
    wpc = 1'b0; exc = 1'b0; br_taken = 1'b0; jmp = 1'b0;
    chk("w8_pc_hold", 32'(pc8), 32'hFC);
    chk("w8_next_wrap", 32'(pc_next8), 32'h00);
    wpc8 = 1'b1;
    sb.push_back('{pc: 32'h00, valid: 1'b1, pend: 1'b0, mis: 1'b0});
    @(posedge clk);
    #1 pop_cmp("w8_wrap", 32'(pc8), valid8, pend8, mis8);
    @(negedge clk);
    br8 = 1'b1; bt8 = 8'h13;
    sb.push_back('{pc: 32'h13, valid: 1'b1, pend: 1'b0, mis: 1'b1});
    @(posedge clk);
    #1 pop_cmp("w8_br", 32'(pc8), valid8, pend8, mis8);
    @(negedge clk);
    br8 = 1'b0;
    sb.push_back('{pc: 32'h17, valid: 1'b1, pend: 1'b0, mis: 1'b1});
    @(posedge clk);
    #1 pop_cmp("w8_seq", 32'(pc8), valid8, pend8, mis8);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
